cavlc_coeff_assembler: RTL and testbench
========================================

Name: cavlc_coeff_assembler

Overview:
Back end of the parametrised CAVLC residual decoder. Takes decoded levels, in reverse scan order, from level decode. Takes total_zeros and run_before values from the run decoder. Places each coefficient at its scan position in a MAX_COEFF-entry buffer, then drains the whole block in order, zeros included, over a valid/ready stream. It generalises 4x4 luma handling to Intra16x16 AC (15), luma 4x4 (16) and chroma DC (4) blocks, and adds backpressure and error flagging.

Parameters:
MAX_COEFF, 16, coefficients per block; legal values are 4, 15 and 16.
LEVEL_W, 13, signed level width, matching the level decoder output.

Ports:
Clk  in  1  clock.
nReset  in  1  asynchronous active-low reset.
Start  in  1  one-cycle pulse that begins a block; TotalCoeff and TotalZeros are sampled on it.
TotalCoeff  in  5  number of nonzero coefficients.
TotalZeros  in  5  zeros preceding the last nonzero coefficient in scan order.
LevelIn  in  LEVEL_W  signed level; the highest-frequency level arrives first.
LevelValid  in  1  LevelIn is valid.
LevelReady  out  1  assembler accepts LevelIn.
RunIn  in  4  run_before value.
RunValid  in  1  RunIn is valid.
RunReady  out  1  assembler accepts RunIn.
CoeffOut  out  LEVEL_W  output coefficient.
CoeffIdx  out  5  scan index of CoeffOut (raster index when CAVLC_ZIGZAG_EN is set).
CoeffValid  out  1  output is valid.
CoeffReady  in  1  downstream accepts the output.
BlockDone  out  1  one-cycle pulse after the final coefficient transfers.
Busy  out  1  high in every state except IDLE.
Error  out  1  sticky error flag, cleared on the next accepted Start.

Behaviour:
- Reset (async, nReset=0): state IDLE; all outputs 0; buffer cleared; pos, zerosLeft and count cleared.
- Transfers happen on valid&ready only. CoeffOut and CoeffIdx hold stable while CoeffValid=1 and CoeffReady=0.
- Start is accepted only in IDLE; Start while Busy is ignored.
- On Start:
  - buffer zeroed;
  - pos = TotalCoeff+TotalZeros-1;
  - zerosLeft = TotalZeros;
  - i = 0;
  - Error cleared, then set if TotalCoeff>MAX_COEFF or TotalCoeff+TotalZeros>MAX_COEFF;
  - next state: TotalCoeff==0 goes to DRAIN, otherwise LEVEL.
- LEVEL: LevelReady=1.
  - On transfer: buf[pos]=LevelIn.
  - If i==TotalCoeff-1, go to DRAIN.
  - Else if zerosLeft>0, go to RUN.
  - Else pos-=1, i+=1, stay in LEVEL.
- RUN: RunReady=1.
  - On transfer: if RunIn>zerosLeft, set Error and clamp RunIn to zerosLeft.
  - Then pos-=run+1, zerosLeft-=run, i+=1, go to LEVEL.
  - The final coefficient never consumes a run; the remaining zerosLeft is implicit.
- Position writes outside 0..MAX_COEFF-1 (possible only in error cases) are suppressed.
- DRAIN:
  - First CoeffValid is asserted the cycle after entry, with k=0.
  - Emits buf[k], CoeffIdx=k, for k=0..MAX_COEFF-1, advancing k on each transfer.
  - The cycle after the transfer at k=MAX_COEFF-1: BlockDone=1 for one cycle and state returns to IDLE.
- Latency:
  - Start to LevelReady is 1 cycle.
  - The last level/run transfer to the first CoeffValid is 1 cycle.
  - With CoeffReady held high, drain takes MAX_COEFF cycles.
- Error does not abort the block; drain always completes with MAX_COEFF outputs.
- Reset mid-block: immediate return to IDLE; no BlockDone.

Optional Feature:
CAVLC_ZIGZAG_EN:
- When defined and MAX_COEFF==16, drain step k emits buf[zz(k)] with CoeffIdx=k, where zz is the 4x4 frame inverse zigzag. Output is therefore in raster order, 0..15.
- When defined and MAX_COEFF!=16, behaviour is identical to the macro being undefined.
- When undefined, drain is in scan order and CoeffIdx is the scan index.

Test Plan:
1. MAX_COEFF=16, Start with TotalCoeff=5, TotalZeros=3. Levels 1,1,-1,-1,3; runs 1,0,2. Expect scan output 3,-1,0,0,-1,1,0,1,0..0 (16 values), no run requested after zerosLeft reaches 0, BlockDone 1 cycle after idx 15, Error=0.
2. TotalCoeff=0 -> no LevelReady or RunReady; 16 zeros out; BlockDone; Busy back to 0.
3. Case 1 with CoeffReady toggling 1/0 every cycle -> identical sequence, CoeffOut stable while stalled, drain takes 32 cycles.
4. TotalCoeff=4, TotalZeros=2, run 3 sent -> Error=1, run clamped to 2, full drain completes; next Start clears Error.
5. MAX_COEFF=4, TotalCoeff=2, TotalZeros=1, levels 5,-2, run 1 -> output -2,0,5,0.
6. Assert nReset during RUN, then Start with case 1 -> all outputs 0 during reset and correct case-1 output afterwards; with CAVLC_ZIGZAG_EN defined, case 1 output equals the raster reorder of the case-1 scan sequence.

Source files
------------

// File: rtl/cavlc_coeff_assembler.sv
// CAVLC residual back end: places levels at scan positions using run_before, then
// drains the whole block over valid/ready. Define CAVLC_ZIGZAG_EN for raster-order drain.
module cavlc_coeff_assembler #(
  parameter int unsigned MAX_COEFF = 16,
  parameter int unsigned LEVEL_W   = 13
) (
  input  logic                      Clk,
  input  logic                      nReset,
  input  logic                      Start,
  input  logic [4:0]                TotalCoeff,
  input  logic [4:0]                TotalZeros,
  input  logic signed [LEVEL_W-1:0] LevelIn,
  input  logic                      LevelValid,
  output logic                      LevelReady,
  input  logic [3:0]                RunIn,
  input  logic                      RunValid,
  output logic                      RunReady,
  output logic signed [LEVEL_W-1:0] CoeffOut,
  output logic [4:0]                CoeffIdx,
  output logic                      CoeffValid,
  input  logic                      CoeffReady,
  output logic                      BlockDone,
  output logic                      Busy,
  output logic                      Error
);

  localparam logic [6:0] MAX_C  = 7'(MAX_COEFF);
  localparam logic [4:0] LAST_K = 5'(MAX_COEFF - 1);
`ifdef CAVLC_ZIGZAG_EN
  localparam bit ZIGZAG = (MAX_COEFF == 16);
`else
  localparam bit ZIGZAG = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_LEVEL, S_RUN, S_DRAIN} state_t;

  state_t                    state_q, state_d;
  logic [6:0]                pos_q, pos_d;
  logic [4:0]                zeros_q, zeros_d;
  logic [4:0]                cnt_q, cnt_d;
  logic [4:0]                tc_q, tc_d;
  logic [4:0]                k_q, k_d;
  logic                      err_q, err_d;
  logic                      done_q, done_d;
  logic                      clr, wr_en;
  logic [5:0]                sum;
  logic [4:0]                run_c;
  logic [4:0]                rd_idx;
  logic signed [LEVEL_W-1:0] rd_val;
  logic signed [LEVEL_W-1:0] coef_q [MAX_COEFF];

  // Raster position k -> scan index holding it (4x4 frame zigzag inverse).
  function automatic logic [4:0] zz(input logic [4:0] k);
    case (k)
      5'd2:    zz = 5'd5;
      5'd3:    zz = 5'd6;
      5'd4:    zz = 5'd2;
      5'd5:    zz = 5'd4;
      5'd6:    zz = 5'd7;
      5'd7:    zz = 5'd12;
      5'd8:    zz = 5'd3;
      5'd9:    zz = 5'd8;
      5'd10:   zz = 5'd11;
      5'd11:   zz = 5'd13;
      5'd12:   zz = 5'd9;
      5'd13:   zz = 5'd10;
      default: zz = k;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    zeros_d = zeros_q;
    cnt_d   = cnt_q;
    tc_d    = tc_q;
    k_d     = k_q;
    err_d   = err_q;
    done_d  = 1'b0;
    clr     = 1'b0;
    wr_en   = 1'b0;
    sum     = {1'b0, TotalCoeff} + {1'b0, TotalZeros};
    run_c   = ({1'b0, RunIn} > zeros_q) ? zeros_q : {1'b0, RunIn};
    case (state_q)
      S_IDLE: if (Start) begin
        clr     = 1'b1;
        pos_d   = {1'b0, sum} - 7'd1;
        zeros_d = TotalZeros;
        cnt_d   = '0;
        tc_d    = TotalCoeff;
        k_d     = '0;
        err_d   = ({2'b0, TotalCoeff} > MAX_C) || ({1'b0, sum} > MAX_C);
        state_d = (TotalCoeff == '0) ? S_DRAIN : S_LEVEL;
      end
      S_LEVEL: if (LevelValid) begin
        wr_en = 1'b1;
        if (cnt_q == tc_q - 5'd1) begin
          k_d     = '0;
          state_d = S_DRAIN;
        end else if (zeros_q != '0) begin
          state_d = S_RUN;
        end else begin
          pos_d = pos_q - 7'd1;
          cnt_d = cnt_q + 5'd1;
        end
      end
      S_RUN: if (RunValid) begin
        if ({1'b0, RunIn} > zeros_q) err_d = 1'b1;
        pos_d   = pos_q - {2'b0, run_c} - 7'd1;
        zeros_d = zeros_q - run_c;
        cnt_d   = cnt_q + 5'd1;
        state_d = S_LEVEL;
      end
      S_DRAIN: if (CoeffReady) begin
        if (k_q == LAST_K) begin
          k_d     = '0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          k_d = k_q + 5'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Full-width compare on read/write: out-of-range positions simply match no entry.
  always_comb begin
    rd_idx = ZIGZAG ? zz(k_q) : k_q;
    rd_val = '0;
    for (int unsigned j = 0; j < MAX_COEFF; j++) begin
      if (rd_idx == 5'(j)) rd_val = coef_q[j];
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q <= S_IDLE;
      pos_q   <= '0;
      zeros_q <= '0;
      cnt_q   <= '0;
      tc_q    <= '0;
      k_q     <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      for (int unsigned j = 0; j < MAX_COEFF; j++) coef_q[j] <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      zeros_q <= zeros_d;
      cnt_q   <= cnt_d;
      tc_q    <= tc_d;
      k_q     <= k_d;
      err_q   <= err_d;
      done_q  <= done_d;
      for (int unsigned j = 0; j < MAX_COEFF; j++) begin
        if (clr) coef_q[j] <= '0;
        else if (wr_en && pos_q == 7'(j)) coef_q[j] <= LevelIn;
      end
    end
  end

  assign LevelReady = (state_q == S_LEVEL);
  assign RunReady   = (state_q == S_RUN);
  assign CoeffValid = (state_q == S_DRAIN);
  assign CoeffOut   = CoeffValid ? rd_val : '0;
  assign CoeffIdx   = CoeffValid ? k_q : '0;
  assign BlockDone  = done_q;
  assign Busy       = (state_q != S_IDLE);
  assign Error      = err_q;

endmodule

// File: tb/tb_cavlc_coeff_assembler.sv
// Bench for cavlc_coeff_assembler: directed vector table, mid-block reset, and random
// blocks against a scan-position reference model on 16- and 4-coefficient instances.
module tb_cavlc_coeff_assembler;
  localparam int LW = 13;

  logic Clk = 1'b0, nReset = 1'b0;
  logic start16 = 1'b0, start4 = 1'b0;
  logic [4:0] TotalCoeff = '0, TotalZeros = '0;
  logic signed [LW-1:0] LevelIn = '0;
  logic LevelValid = 1'b0, RunValid = 1'b0, CoeffReady = 1'b0;
  logic [3:0] RunIn = '0;

  logic lr16, rr16, cv16, bd16, busy16, err16;
  logic signed [LW-1:0] co16;
  logic [4:0] ci16;
  logic lr4, rr4, cv4, bd4, busy4, err4;
  logic signed [LW-1:0] co4;
  logic [4:0] ci4;

  logic lr, rr, cv, bd, busy, err;
  logic signed [LW-1:0] cout;
  logic [4:0] cidx;
  bit sel4 = 1'b0;

  always #5 Clk = ~Clk;

  cavlc_coeff_assembler #(.MAX_COEFF(16), .LEVEL_W(LW)) u16 (
    .Clk(Clk), .nReset(nReset), .Start(start16), .TotalCoeff(TotalCoeff), .TotalZeros(TotalZeros),
    .LevelIn(LevelIn), .LevelValid(LevelValid), .LevelReady(lr16), .RunIn(RunIn), .RunValid(RunValid),
    .RunReady(rr16), .CoeffOut(co16), .CoeffIdx(ci16), .CoeffValid(cv16), .CoeffReady(CoeffReady),
    .BlockDone(bd16), .Busy(busy16), .Error(err16));

  cavlc_coeff_assembler #(.MAX_COEFF(4), .LEVEL_W(LW)) u4 (
    .Clk(Clk), .nReset(nReset), .Start(start4), .TotalCoeff(TotalCoeff), .TotalZeros(TotalZeros),
    .LevelIn(LevelIn), .LevelValid(LevelValid), .LevelReady(lr4), .RunIn(RunIn), .RunValid(RunValid),
    .RunReady(rr4), .CoeffOut(co4), .CoeffIdx(ci4), .CoeffValid(cv4), .CoeffReady(CoeffReady),
    .BlockDone(bd4), .Busy(busy4), .Error(err4));

  always_comb begin
    lr = sel4 ? lr4 : lr16;     rr = sel4 ? rr4 : rr16;
    cv = sel4 ? cv4 : cv16;     bd = sel4 ? bd4 : bd16;
    busy = sel4 ? busy4 : busy16; err = sel4 ? err4 : err16;
    cout = sel4 ? co4 : co16;   cidx = sel4 ? ci4 : ci16;
  end

`ifdef CAVLC_ZIGZAG_EN
  localparam bit ZZ_ON = 1'b1;
`else
  localparam bit ZZ_ON = 1'b0;
`endif
  int zz_scan [16] = '{0, 1, 4, 8, 5, 2, 3, 6, 9, 12, 13, 10, 7, 11, 14, 15};

  typedef struct packed {
    logic              sel4;
    logic [4:0]        tc;
    logic [4:0]        tz;
    logic [0:4][12:0]  lev;
    logic [2:0]        nrun;
    logic [0:3][3:0]   run;
    logic [1:0]        rmode;
    logic [0:15][12:0] exp;
    logic              err;
  } vec_t;
  vec_t tbl [6];

  int errors = 0, checks = 0;
  int n_max, cur_tc, cur_tz, nlev, nrun, rmode;
  logic signed [LW-1:0] lev_a [32];
  logic [3:0] run_a [32];
  logic signed [LW-1:0] exp_a [16];
  bit exp_err;

  task automatic check(input bit ok, input string name, input string act, input string req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %s, expected %s", name, act, req);
    end
  endtask

  function automatic string seq_str(input logic signed [LW-1:0] a [16], input int n);
    string s = "";
    for (int i = 0; i < n && i < 16; i++) s = {s, $sformatf("%0d ", a[i])};
    return s;
  endfunction

  task automatic check_reset_outputs(input string name);
    bit ok;
    ok = !lr16 && !rr16 && !cv16 && co16 == 0 && ci16 == 0 && !bd16 && !busy16 && !err16 &&
         !lr4 && !rr4 && !cv4 && co4 == 0 && ci4 == 0 && !bd4 && !busy4 && !err4;
    check(ok, name, $sformatf("lr=%0b rr=%0b cv=%0b out=%0d idx=%0d bd=%0b busy=%0b err=%0b / u4 busy=%0b cv=%0b err=%0b",
          lr16, rr16, cv16, co16, ci16, bd16, busy16, err16, busy4, cv4, err4), "all outputs 0");
  endtask

  task automatic load_vec(input int t);
    sel4 = tbl[t].sel4;
    n_max = tbl[t].sel4 ? 4 : 16;
    cur_tc = int'(tbl[t].tc);
    cur_tz = int'(tbl[t].tz);
    nlev = cur_tc;
    nrun = int'(tbl[t].nrun);
    rmode = int'(tbl[t].rmode);
    exp_err = tbl[t].err;
    for (int i = 0; i < 32; i++) begin lev_a[i] = '0; run_a[i] = '0; end
    for (int i = 0; i < 5; i++) lev_a[i] = $signed(tbl[t].lev[i]);
    for (int i = 0; i < 4; i++) run_a[i] = tbl[t].run[i];
    for (int k = 0; k < 16; k++) exp_a[k] = $signed(tbl[t].exp[k]);
  endtask

  // Reference: the first level lands at TC+TZ-1; each later coefficient sits one below the
  // previous minus the run taken there, runs are only drawn while zeros remain and are clamped.
  task automatic gen_random(input bit to4);
    int p, zl, r;
    sel4 = to4;
    n_max = to4 ? 4 : 16;
    cur_tc = int'($urandom_range(0, n_max));
    if ($urandom_range(7) == 0) cur_tc = int'($urandom_range(0, n_max + 4));
    cur_tz = (cur_tc <= n_max) ? int'($urandom_range(0, n_max - cur_tc)) : 0;
    if ($urandom_range(7) == 0) cur_tz = int'($urandom_range(0, 15));
    nlev = cur_tc;
    rmode = 2;
    for (int i = 0; i < 32; i++) begin
      lev_a[i] = 13'($urandom_range(1, 2000));
      if ($urandom_range(1) == 1) lev_a[i] = -lev_a[i];
      run_a[i] = ($urandom_range(4) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
    end
    for (int k = 0; k < 16; k++) exp_a[k] = '0;
    exp_err = (cur_tc > n_max) || (cur_tc + cur_tz > n_max);
    p = cur_tc + cur_tz - 1;
    zl = cur_tz;
    nrun = 0;
    for (int c = 0; c < cur_tc; c++) begin
      if (p >= 0 && p < n_max) exp_a[p] = lev_a[c];
      if (c == cur_tc - 1) break;
      if (zl > 0) begin
        r = int'(run_a[nrun]);
        nrun++;
        if (r > zl) begin exp_err = 1'b1; r = zl; end
        zl -= r;
        p -= r + 1;
      end else begin
        p -= 1;
      end
    end
  endtask

  task automatic run_block(input string nm);
    int li, ri, cyc, cv_cyc, nx, extra, last_x, bd_cyc;
    bit done, pend, lat_ok, idx_ok, stable, prev_stall, rdy, lv, err_at_bd, start_ok, seq_ok;
    logic signed [LW-1:0] got [16];
    logic signed [LW-1:0] want [16];
    logic signed [LW-1:0] pco;
    logic [4:0] pci;
    li = 0; ri = 0; cyc = 0; cv_cyc = 0; nx = 0; extra = 0; last_x = -10; bd_cyc = -1;
    done = 0; pend = 0; lat_ok = 1; idx_ok = 1; stable = 1; prev_stall = 0; err_at_bd = 0;
    pco = '0; pci = '0;
    for (int k = 0; k < 16; k++) got[k] = '0;

    @(negedge Clk);
    TotalCoeff = 5'(cur_tc);
    TotalZeros = 5'(cur_tz);
    if (sel4) start4 = 1'b1; else start16 = 1'b1;
    @(negedge Clk);
    start4 = 1'b0; start16 = 1'b0;
    start_ok = (cur_tc > 0) ? (lr && !cv && busy) : (cv && !lr && busy);
    check(start_ok, {nm, " start_latency"}, $sformatf("lr=%0b cv=%0b busy=%0b", lr, cv, busy),
          (cur_tc > 0) ? "lr=1 cv=0 busy=1" : "lr=0 cv=1 busy=1");

    while (!done && cyc < 600) begin
      if (pend) begin
        if (!cv) lat_ok = 0;
        pend = 0;
      end
      if (bd) begin done = 1; bd_cyc = cyc; err_at_bd = err; end
      lv = (li < nlev) && (rmode != 2 || $urandom_range(3) != 0);
      LevelValid = lv;
      LevelIn = lev_a[li];
      if (lr && li >= nlev) extra++;
      if (lr && lv) begin
        li++;
        if (li == nlev) pend = 1;
      end
      RunValid = (ri < nrun);
      RunIn = run_a[ri];
      if (rr && ri >= nrun) extra++;
      if (rr && ri < nrun) ri++;
      if (cv) begin
        if (prev_stall && (cout !== pco || cidx !== pci)) stable = 0;
        rdy = (rmode == 0) ? 1'b1 : (rmode == 1) ? cv_cyc[0] : ($urandom_range(1) == 1);
        if (rdy) begin
          if (nx < 16) got[nx] = cout;
          if (cidx != 5'(nx)) idx_ok = 0;
          nx++;
          last_x = cyc;
        end
        prev_stall = !rdy;
        pco = cout;
        pci = cidx;
        cv_cyc++;
      end else begin
        if (prev_stall) stable = 0;
        rdy = 1'b0;
        prev_stall = 0;
      end
      CoeffReady = rdy;
      @(negedge Clk);
      cyc++;
    end
    LevelValid = 1'b0; RunValid = 1'b0; CoeffReady = 1'b0;

    check(done, {nm, " timeout"}, $sformatf("no BlockDone in %0d cycles", cyc), "BlockDone");
    for (int k = 0; k < 16; k++) want[k] = exp_a[k];
    if (ZZ_ON && !sel4) for (int s = 0; s < 16; s++) want[zz_scan[s]] = exp_a[s];
    seq_ok = (nx == n_max);
    for (int k = 0; k < n_max; k++) if (got[k] !== want[k]) seq_ok = 0;
    check(seq_ok, {nm, " data"}, $sformatf("n=%0d [%s]", nx, seq_str(got, nx)),
          $sformatf("n=%0d [%s]", n_max, seq_str(want, n_max)));
    check(idx_ok && stable, {nm, " idx_stall"}, $sformatf("idx_ok=%0b stable=%0b", idx_ok, stable),
          "idx_ok=1 stable=1");
    check(extra == 0 && li == nlev && ri == nrun, {nm, " handshake"},
          $sformatf("levels=%0d runs=%0d extra=%0d", li, ri, extra),
          $sformatf("levels=%0d runs=%0d extra=0", nlev, nrun));
    if (nlev > 0) check(lat_ok, {nm, " last_to_valid"}, "CoeffValid late", "CoeffValid 1 cycle after last level");
    if (rmode < 2) check(cv_cyc == n_max * (rmode + 1), {nm, " drain_cycles"},
                         $sformatf("%0d", cv_cyc), $sformatf("%0d", n_max * (rmode + 1)));
    check(bd_cyc == last_x + 1, {nm, " blockdone_timing"}, $sformatf("bd@%0d last@%0d", bd_cyc, last_x),
          "bd one cycle after last transfer");
    check(err_at_bd == exp_err, {nm, " error"}, $sformatf("%0b", err_at_bd), $sformatf("%0b", exp_err));
    check(!busy && !bd, {nm, " idle_after"}, $sformatf("busy=%0b bd=%0b", busy, bd), "busy=0 bd=0");
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{sel4: 1'b0, tc: 5'd5, tz: 5'd3,
               lev: {13'sd1, 13'sd1, -13'sd1, -13'sd1, 13'sd3}, nrun: 3'd3,
               run: {4'd1, 4'd0, 4'd2, 4'd0}, rmode: 2'd0,
               exp: {13'sd3, -13'sd1, 13'sd0, 13'sd0, -13'sd1, 13'sd1, 13'sd0, 13'sd1, {8{13'sd0}}},
               err: 1'b0};
    tbl[1] = '{sel4: 1'b0, tc: 5'd0, tz: 5'd0, lev: '0, nrun: 3'd0, run: '0, rmode: 2'd0,
               exp: '0, err: 1'b0};
    tbl[2] = tbl[0];
    tbl[2].rmode = 2'd1;
    tbl[3] = '{sel4: 1'b0, tc: 5'd4, tz: 5'd2,
               lev: {13'sd2, -13'sd3, 13'sd4, -13'sd5, 13'sd0}, nrun: 3'd1,
               run: {4'd3, 4'd0, 4'd0, 4'd0}, rmode: 2'd0,
               exp: {-13'sd5, 13'sd4, -13'sd3, 13'sd0, 13'sd0, 13'sd2, {10{13'sd0}}},
               err: 1'b1};
    tbl[4] = tbl[0];
    tbl[5] = '{sel4: 1'b1, tc: 5'd2, tz: 5'd1,
               lev: {13'sd5, -13'sd2, 13'sd0, 13'sd0, 13'sd0}, nrun: 3'd1,
               run: {4'd1, 4'd0, 4'd0, 4'd0}, rmode: 2'd0,
               exp: {-13'sd2, 13'sd0, 13'sd5, {13{13'sd0}}}, err: 1'b0};

    repeat (2) @(negedge Clk);
    check_reset_outputs("reset_state");
    nReset = 1'b1;

    for (int t = 0; t < 6; t++) begin
      load_vec(t);
      run_block($sformatf("vec%0d", t));
    end

    // Reset while the block waits for a run, then a clean block.
    sel4 = 1'b0;
    @(negedge Clk);
    TotalCoeff = 5'd5; TotalZeros = 5'd3; start16 = 1'b1;
    @(negedge Clk);
    start16 = 1'b0; LevelValid = 1'b1; LevelIn = 13'sd1;
    @(negedge Clk);
    LevelValid = 1'b0;
    check(rr16 && busy16, "midblock_in_run", $sformatf("rr=%0b busy=%0b", rr16, busy16), "rr=1 busy=1");
    #2 nReset = 1'b0;
    #1 check_reset_outputs("midblock_reset_async");
    @(negedge Clk);
    check_reset_outputs("midblock_reset_held");
    nReset = 1'b1;
    load_vec(0);
    run_block("after_reset");

    for (int n = 0; n < 40; n++) begin
      gen_random(1'b0);
      run_block($sformatf("rnd16_%0d", n));
    end
    for (int n = 0; n < 12; n++) begin
      gen_random(1'b1);
      run_block($sformatf("rnd4_%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
